// File: rtl/control_cmd_readarea_if.sv
// Command, framebuffer-RAM and transmit signals shared by the read-area handler
// and the command dispatcher side.
interface control_cmd_readarea_if #(
  parameter int unsigned ROW_W = 5,
  parameter int unsigned COL_W = 6,
  parameter int unsigned PIX_W = 1
) ();
  logic             enable;
  logic [7:0]       data_in;
  logic             ready_for_data;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] column;
  logic [PIX_W-1:0] pixel;
  logic             ram_read_enable;
  logic             ram_access_start;
  logic [7:0]       ram_data_in;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;

  // Dispatcher side: feeds command bytes and RAM data, consumes tx bytes
  modport master (
    output enable, data_in, ram_data_in, tx_ready,
    input  ready_for_data, row, column, pixel, ram_read_enable, ram_access_start,
           tx_data, tx_valid
  );

  // Read-area handler side
  modport slave (
    input  enable, data_in, ram_data_in, tx_ready,
    output ready_for_data, row, column, pixel, ram_read_enable, ram_access_start,
           tx_data, tx_valid
  );
endinterface

// File: rtl/control_cmd_readarea.sv
// Read-area command: captures x1,y1,width,height, reads the clipped rectangle from
// framebuffer RAM byte by byte and returns it over tx. Optional CONTROL_CMD_READAREA_TRAILER_EN.
package params_pkg;
  localparam int unsigned PIXEL_WIDTH     = 64;
  localparam int unsigned PIXEL_HEIGHT    = 32;
  localparam int unsigned BYTES_PER_PIXEL = 2;
  localparam int unsigned NUM_ROW_ADDRESS_BITS      = $clog2(PIXEL_HEIGHT);
  localparam int unsigned NUM_COLUMN_ADDRESS_BITS   = $clog2(PIXEL_WIDTH);
  localparam int unsigned NUM_PIXELCOLORSELECT_BITS =
    (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
endpackage

module control_cmd_readarea
  import params_pkg::*;
#(
  parameter int unsigned RAM_READ_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  control_cmd_readarea_if.slave  bus,
  output logic                   done
);

  localparam int unsigned ROW_W = NUM_ROW_ADDRESS_BITS;
  localparam int unsigned COL_W = NUM_COLUMN_ADDRESS_BITS;
  localparam int unsigned PIX_W = NUM_PIXELCOLORSELECT_BITS;

  typedef enum logic [2:0] {
    S_CAPTURE, S_CLAMP, S_ISSUE, S_WAIT, S_HOLD, S_TRAILER, S_FINISH
  } state_t;

  state_t           state;
  logic [1:0]       cap_idx;
  logic [7:0]       x1, y1, wid, hgt;
  logic [COL_W-1:0] x_start, x_end;
  logic [ROW_W-1:0] y_end;
  logic [2:0]       lat_cnt;
  logic             ready_r, rd_en_r, start_r, tx_valid_r;
  logic [ROW_W-1:0] row_r;
  logic [COL_W-1:0] col_r;
  logic [PIX_W-1:0] pix_r;
  logic [7:0]       tx_data_r;
`ifdef CONTROL_CMD_READAREA_TRAILER_EN
  logic [7:0]       xor_acc;
`endif

  logic [8:0] eff_w_c, eff_h_c;

  // Length of a span starting at start, clipped to [0, limit)
  function automatic logic [8:0] clamp_len(input logic [7:0] start, input logic [7:0] len,
                                           input logic [8:0] limit);
    logic [8:0] room;
    if ({1'b0, start} >= limit) return 9'd0;
    room = limit - {1'b0, start};
    return ({1'b0, len} < room) ? {1'b0, len} : room;
  endfunction

  assign eff_w_c = clamp_len(x1, wid, 9'(PIXEL_WIDTH));
  assign eff_h_c = clamp_len(y1, hgt, 9'(PIXEL_HEIGHT));

  assign bus.ready_for_data   = ready_r;
  assign bus.row              = row_r;
  assign bus.column           = col_r;
  assign bus.pixel            = pix_r;
  assign bus.ram_read_enable  = rd_en_r;
  assign bus.ram_access_start = start_r;
  assign bus.tx_data          = tx_data_r;
  assign bus.tx_valid         = tx_valid_r;

  // Command sequencer; all outputs are registered alongside the state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_CAPTURE;
      cap_idx    <= 2'd0;
      x1         <= 8'd0;
      y1         <= 8'd0;
      wid        <= 8'd0;
      hgt        <= 8'd0;
      x_start    <= '0;
      x_end      <= '0;
      y_end      <= '0;
      lat_cnt    <= 3'd0;
      ready_r    <= 1'b1;
      rd_en_r    <= 1'b0;
      start_r    <= 1'b0;
      tx_valid_r <= 1'b0;
      row_r      <= '0;
      col_r      <= '0;
      pix_r      <= '0;
      tx_data_r  <= 8'd0;
      done       <= 1'b0;
`ifdef CONTROL_CMD_READAREA_TRAILER_EN
      xor_acc    <= 8'd0;
`endif
    end else begin
      case (state)
        S_CAPTURE: begin
          if (bus.enable) begin
            case (cap_idx)
              2'd0:    x1  <= bus.data_in;
              2'd1:    y1  <= bus.data_in;
              2'd2:    wid <= bus.data_in;
              default: hgt <= bus.data_in;
            endcase
            cap_idx <= 2'(cap_idx + 2'd1);
            if (cap_idx == 2'd3) begin
              ready_r <= 1'b0;
              state   <= S_CLAMP;
            end
          end
        end

        S_CLAMP: begin
`ifdef CONTROL_CMD_READAREA_TRAILER_EN
          xor_acc <= 8'd0;
`endif
          if (eff_w_c == 9'd0 || eff_h_c == 9'd0) begin
`ifdef CONTROL_CMD_READAREA_TRAILER_EN
            tx_data_r  <= 8'd0;
            tx_valid_r <= 1'b1;
            state      <= S_TRAILER;
`else
            done  <= 1'b1;
            state <= S_FINISH;
`endif
          end else begin
            row_r   <= ROW_W'(y1);
            col_r   <= COL_W'(x1);
            pix_r   <= PIX_W'(BYTES_PER_PIXEL - 1);
            x_start <= COL_W'(x1);
            x_end   <= COL_W'(9'(x1) + eff_w_c - 9'd1);
            y_end   <= ROW_W'(9'(y1) + eff_h_c - 9'd1);
            start_r <= 1'b1;
            rd_en_r <= 1'b1;
            state   <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          start_r <= 1'b0;
          lat_cnt <= 3'(RAM_READ_LATENCY - 1);
          state   <= S_WAIT;
        end

        S_WAIT: begin
          if (lat_cnt == 3'd0) begin
            tx_data_r  <= bus.ram_data_in;
            tx_valid_r <= 1'b1;
            rd_en_r    <= 1'b0;
`ifdef CONTROL_CMD_READAREA_TRAILER_EN
            xor_acc    <= xor_acc ^ bus.ram_data_in;
`endif
            state      <= S_HOLD;
          end else begin
            lat_cnt <= 3'(lat_cnt - 3'd1);
          end
        end

        // Advance pixel, then column, then row once the byte is accepted
        S_HOLD: begin
          if (bus.tx_ready) begin
            tx_valid_r <= 1'b0;
            if (pix_r != '0) begin
              pix_r   <= PIX_W'(pix_r - 1'b1);
              start_r <= 1'b1;
              rd_en_r <= 1'b1;
              state   <= S_ISSUE;
            end else if (col_r != x_end) begin
              pix_r   <= PIX_W'(BYTES_PER_PIXEL - 1);
              col_r   <= COL_W'(col_r + 1'b1);
              start_r <= 1'b1;
              rd_en_r <= 1'b1;
              state   <= S_ISSUE;
            end else if (row_r != y_end) begin
              pix_r   <= PIX_W'(BYTES_PER_PIXEL - 1);
              col_r   <= x_start;
              row_r   <= ROW_W'(row_r + 1'b1);
              start_r <= 1'b1;
              rd_en_r <= 1'b1;
              state   <= S_ISSUE;
            end else begin
`ifdef CONTROL_CMD_READAREA_TRAILER_EN
              tx_data_r  <= xor_acc;
              tx_valid_r <= 1'b1;
              state      <= S_TRAILER;
`else
              done  <= 1'b1;
              state <= S_FINISH;
`endif
            end
          end
        end

        S_TRAILER: begin
          if (bus.tx_ready) begin
            tx_valid_r <= 1'b0;
            done       <= 1'b1;
            state      <= S_FINISH;
          end
        end

        S_FINISH: begin
          done    <= 1'b0;
          ready_r <= 1'b1;
          cap_idx <= 2'd0;
          state   <= S_CAPTURE;
        end

        default: state <= S_CAPTURE;
      endcase
    end
  end

endmodule
